// File: rtl/mac_frame_byte_serializer.sv
// -----------------------------------------------------------------------------
// mac_frame_byte_serializer
//
// Upstream feeder for the multi-lane controller. Takes MAC_FRAME_WIDTH-bit
// words from the Data Link Layer and emits them one byte at a time, LSB byte
// first. Each packet is framed with an STP control symbol before the first
// data byte and an END control symbol after the last valid byte. The last
// word of a packet may be partial; its last valid byte index is supplied with
// the eop word.
//
// Ports
//   clk_i                   single clock
//   rst_ni                  asynchronous active-low reset
//   mac_data_frame_i        input word, byte 0 = bits [7:0], sent first
//   mac_data_frame_valid_i  input word valid
//   mac_data_frame_ready_o  block accepts the word this cycle
//   mac_sop_i               word is the first of a packet
//   mac_eop_i               word is the last of a packet
//   mac_last_byte_idx_i     last valid byte index on an eop word
//   data_frame_o            output byte
//   data_frame_is_k_o       1 = control symbol (STP/END), 0 = data byte
//   data_frame_valid_o      output byte valid
//   data_frame_ready_i      downstream accepts the byte
//   busy_o                  packet in flight
//   proto_err_o             one-cycle pulse after a framing violation
// -----------------------------------------------------------------------------
module mac_frame_byte_serializer #(
    parameter int          MAC_FRAME_WIDTH = 32,
    parameter logic [7:0]  STP_SYMBOL      = 8'hFB,
    parameter logic [7:0]  END_SYMBOL      = 8'hFD,
    localparam int         NB              = MAC_FRAME_WIDTH / 8,
    localparam int         IDX_W           = $clog2(NB)
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [MAC_FRAME_WIDTH-1:0] mac_data_frame_i,
    input  logic                       mac_data_frame_valid_i,
    output logic                       mac_data_frame_ready_o,
    input  logic                       mac_sop_i,
    input  logic                       mac_eop_i,
    input  logic [IDX_W-1:0]           mac_last_byte_idx_i,
    output logic [7:0]                 data_frame_o,
    output logic                       data_frame_is_k_o,
    output logic                       data_frame_valid_o,
    input  logic                       data_frame_ready_i,
    output logic                       busy_o,
    output logic                       proto_err_o
);

    // Elaboration-time guard: the byte slicing below assumes whole bytes and
    // at least two of them (so the index field is never zero bits wide).
    if ((MAC_FRAME_WIDTH % 8) != 0 || MAC_FRAME_WIDTH < 16) begin : g_bad_width
        $error("MAC_FRAME_WIDTH must be a multiple of 8 and at least 16");
    end

    localparam logic [IDX_W-1:0] LAST_FULL = IDX_W'(NB - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_STP  = 3'd1,
        S_DATA = 3'd2,
        S_WAIT = 3'd3,
        S_END  = 3'd4
    } state_e;

    state_e                     state_q, state_d;
    logic [MAC_FRAME_WIDTH-1:0] word_q, word_d;
    logic                       eop_q, eop_d;
    logic [IDX_W-1:0]           last_q, last_d;
    logic [IDX_W-1:0]           idx_q, idx_d;
    logic                       proto_err_q, proto_err_d;

    logic                       valid_int;
    logic                       is_k_int;
    logic [7:0]                 byte_int;
    logic                       ready_int;
    logic [7:0]                 cur_byte;
    logic                       at_last;
    logic                       out_hs;
    logic                       in_hs;
    logic                       capture;

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            word_q      <= '0;
            eop_q       <= 1'b0;
            last_q      <= '0;
            idx_q       <= '0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            word_q      <= word_d;
            eop_q       <= eop_d;
            last_q      <= last_d;
            idx_q       <= idx_d;
            proto_err_q <= proto_err_d;
        end
    end

    // Byte currently addressed by idx_q; a compare-based mux keeps the select
    // width-exact for any NB.
    always_comb begin
        cur_byte = '0;
        for (int i = 0; i < NB; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_byte = word_q[8*i +: 8];
            end
        end
    end

    assign at_last = (idx_q == last_q);
    assign out_hs  = valid_int & data_frame_ready_i;
    assign in_hs   = mac_data_frame_valid_i & mac_data_frame_ready_o;

    // -------------------------------------------------------------------------
    // Next-state and datapath update
    // -------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        word_d      = word_q;
        eop_d       = eop_q;
        last_d      = last_q;
        idx_d       = idx_q;
        proto_err_d = 1'b0;
        capture     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (in_hs) begin
                    if (mac_sop_i) begin
                        capture = 1'b1;
                        state_d = S_STP;
                    end else begin
                        // Orphan word outside a packet: dropped.
                        proto_err_d = 1'b1;
                    end
                end
            end
            S_STP: begin
                if (out_hs) begin
                    idx_d   = '0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (out_hs) begin
                    if (!at_last) begin
                        idx_d = idx_q + IDX_W'(1);
                    end else if (eop_q) begin
                        state_d = S_END;
                    end else if (in_hs) begin
                        // Next word lands on the same edge as the last byte
                        // leaves: stream on without a bubble.
                        capture     = 1'b1;
                        proto_err_d = mac_sop_i;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (in_hs) begin
                    capture     = 1'b1;
                    proto_err_d = mac_sop_i;
                    state_d     = S_DATA;
                end
            end
            S_END: begin
                if (out_hs) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Non-eop words are always full, so their last index is NB-1.
        if (capture) begin
            word_d = mac_data_frame_i;
            eop_d  = mac_eop_i;
            last_d = mac_eop_i ? mac_last_byte_idx_i : LAST_FULL;
            idx_d  = '0;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs decoded from the current state
    // -------------------------------------------------------------------------
    always_comb begin
        valid_int = 1'b0;
        is_k_int  = 1'b0;
        byte_int  = '0;
        ready_int = 1'b0;

        case (state_q)
            S_IDLE: begin
                ready_int = 1'b1;
            end
            S_STP: begin
                valid_int = 1'b1;
                is_k_int  = 1'b1;
                byte_int  = STP_SYMBOL;
            end
            S_DATA: begin
                valid_int = 1'b1;
                byte_int  = cur_byte;
                // Only the final byte of a non-eop word may pull in the next
                // word, and only when that byte is actually leaving.
                if (at_last && !eop_q) begin
                    ready_int = data_frame_ready_i;
                end
            end
            S_WAIT: begin
                ready_int = 1'b1;
            end
            S_END: begin
                valid_int = 1'b1;
                is_k_int  = 1'b1;
                byte_int  = END_SYMBOL;
            end
            default: begin
                ready_int = 1'b0;
            end
        endcase
    end

    // IDLE would otherwise advertise ready while reset is held.
    assign mac_data_frame_ready_o = ready_int & rst_ni;
    assign data_frame_valid_o     = valid_int;
    assign data_frame_is_k_o      = is_k_int;
    assign data_frame_o           = byte_int;
    assign busy_o                 = (state_q != S_IDLE);
    assign proto_err_o            = proto_err_q;

endmodule

// File: doc/mac_frame_byte_serializer.md
Name: mac_frame_byte_serializer

Overview:
- Upstream feeder for the multi-lane controller. Converts MAC_FRAME_WIDTH-bit frames from the Data Link Layer into a framed byte stream.
- Wraps each packet with an STP control symbol before the first data byte and an END control symbol after the last valid byte.
- Valid/ready handshake on both sides. Replaces the current truncate-to-low-byte path in the PHY top.

Parameters:
- MAC_FRAME_WIDTH, 32, input frame width in bits; must be a multiple of 8 and at least 16. NB = MAC_FRAME_WIDTH/8.
- STP_SYMBOL, 8'hFB, K27.7 start-of-packet control byte.
- END_SYMBOL, 8'hFD, K29.7 end-of-packet control byte.

Ports:
- clk_i  in  1  single clock for the block.
- rst_ni  in  1  asynchronous, active-low reset.
- mac_data_frame_i  in  MAC_FRAME_WIDTH  frame word; byte 0 = bits [7:0] and is transmitted first.
- mac_data_frame_valid_i  in  1  frame word valid.
- mac_data_frame_ready_o  out  1  block accepts the word this cycle.
- mac_sop_i  in  1  word is the first of a packet.
- mac_eop_i  in  1  word is the last of a packet.
- mac_last_byte_idx_i  in  $clog2(NB)  index of the last valid byte on an eop word; ignored otherwise.
- data_frame_o  out  8  output byte.
- data_frame_is_k_o  out  1  1 = control symbol (STP/END), 0 = data byte.
- data_frame_valid_o  out  1  output byte valid.
- data_frame_ready_i  in  1  downstream accepts the byte.
- busy_o  out  1  packet in flight (state != IDLE).
- proto_err_o  out  1  one-cycle pulse on a framing violation.

Behaviour:
- Input handshake: a word transfers when valid & ready are high. Output handshake: a byte transfers when valid & ready are high.
- Once data_frame_valid_o is raised, data_frame_o, data_frame_is_k_o and data_frame_valid_o hold stable until the output handshake completes.
- Registers:
  - state: IDLE, STP, DATA, WAIT, END.
  - word_q (captured frame).
  - eop_q and last_q (captured eop flag and last byte index; last_q = NB-1 for non-eop words).
  - idx_q (byte index).
- Reset (async assert, sync deassert at the next clk_i edge): state=IDLE, word_q=0, idx_q=0, eop_q=0, last_q=0.
  - While rst_ni is low: data_frame_valid_o=0, data_frame_o=0, data_frame_is_k_o=0, mac_data_frame_ready_o=0, busy_o=0, proto_err_o=0.
  - A reset mid-packet abandons the packet. No END is emitted.
- IDLE: ready_o=1, valid_o=0.
  - Accepted word with sop=1: capture word, eop and last index; go to STP.
  - Accepted word with sop=0: discard it, pulse proto_err_o, stay in IDLE.
- STP: present STP_SYMBOL with is_k=1, ready_o=0. On output handshake: idx_q=0, go to DATA.
- DATA: present word_q[8*idx_q +: 8] with is_k=0.
  - Handshake with idx_q != last_q: idx_q++.
  - Handshake with idx_q == last_q and eop_q=1: go to END.
  - Handshake with idx_q == last_q and eop_q=0: ready_o = data_frame_ready_i (combinational) in this cycle.
    - If a word is accepted simultaneously, capture it, set idx_q=0 and stay in DATA. This gives zero-bubble streaming.
    - Otherwise go to WAIT.
  - ready_o=0 in every other DATA cycle.
- WAIT: valid_o=0, ready_o=1. On an accepted word: capture it, idx_q=0, go to DATA.
- sop=1 on any mid-packet word (DATA or WAIT): pulse proto_err_o; the word is treated as a continuation (sop ignored).
- END: present END_SYMBOL with is_k=1, ready_o=0. On output handshake: go to IDLE.
- Latency: sop word accepted at edge N -> STP visible after edge N (cycle N+1). First data byte follows at the earliest one cycle later.
- Throughput with data_frame_ready_i held high: a packet of W words whose last word has index L occupies 2 + NB*(W-1) + (L+1) output cycles, with no gaps.
- busy_o = (state != IDLE).

Test Plan:
- Single-word packet, word 32'hDDCCBBAA, sop=eop=1, last idx 3, ready_i held 1 -> bytes FB(k) AA BB CC DD FD(k) on 6 consecutive cycles; busy_o high 6 cycles.
- Two-word packet 32'h44332211 then 32'h00007766 (eop, last idx 1), valid held -> FB 11 22 33 44 66 77 FD; second word accepted in the same cycle as byte 44 with no output gap.
- Backpressure: toggle data_frame_ready_i 1/0 each cycle during the single-word case -> identical byte sequence; outputs stable during every ready=0 cycle.
- Upstream starvation: first word non-eop, second word delayed 5 cycles -> 5 cycles of valid_o=0 (WAIT) after the last byte of the first word, then the stream resumes.
- Protocol errors: word with sop=0 in IDLE -> dropped, proto_err_o pulses once, no output. sop=1 on the second word of a packet -> proto_err_o pulse, data still serialized.
- Reset mid-packet: assert rst_ni low after byte BB -> valid_o and ready_o drop to 0 immediately. After release, a new sop packet is framed correctly starting with FB.
